// File: rtl/vga_timing_gen.sv
// Purpose : VGA raster timing: pixel-rate enable, x/y counters, active-low syncs, video_on, frame_tick.
// Latency : hsync/vsync/video_on/pixel_tick/frame_tick are registered and coherent with x/y every cycle.
// Backpr. : none; free-running generator, only rst stops it.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset (from the reset synchronizer)
//   pixel_tick out  high in the last clk of each pixel period
//   x, y       out  raster position, 0..H_TOTAL-1 / 0..V_TOTAL-1
//   hsync      out  horizontal sync, active low
//   vsync      out  vertical sync, active low
//   video_on   out  high inside the visible area
//   frame_tick out  one-clk pulse on entry to (0, V_VISIBLE), start of vertical blanking
module vga_timing_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pixel_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] Y_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [3:0] div_q, div_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       pixel_tick_q, pixel_tick_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_on_q, video_on_d;
    logic       frame_tick_q, frame_tick_d;
    logic       adv;

    always_comb begin
        adv          = (div_q == DIV_LAST);
        div_d        = adv ? 4'd0 : div_q + 4'd1;
        x_d          = x_q;
        y_d          = y_q;

        if (adv) begin
            if (x_q == X_LAST) begin
                x_d = 10'd0;
                y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end

        // All flag registers decode the next-state counters so that they
        // line up with x/y in the same cycle without an output-side comb path.
        pixel_tick_d = (div_d == DIV_LAST);
        hsync_d      = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
        vsync_d      = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
        video_on_d   = (x_d < X_VIS) && (y_d < Y_VIS);
        // Only on the step that enters (0, V_VISIBLE), not for the whole pixel.
        frame_tick_d = adv && (x_d == 10'd0) && (y_d == Y_VIS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= 4'd0;
            x_q          <= 10'd0;
            y_q          <= 10'd0;
            pixel_tick_q <= (CLK_DIV == 1);
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            video_on_q   <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            x_q          <= x_d;
            y_q          <= y_d;
            pixel_tick_q <= pixel_tick_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            video_on_q   <= video_on_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign pixel_tick = pixel_tick_q;
    assign x          = x_q;
    assign y          = y_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign video_on   = video_on_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Purpose : self-checking bench for vga_timing_gen on three raster configurations.
// Latency : outputs sampled on the falling edge, half a clock after each update.
// Backpr. : none.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    // a: default raster, CLK_DIV 4. b: medium raster, CLK_DIV 3. c: tiny raster, CLK_DIV 1.
    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic pt_a, hs_a, vs_a, von_a, ft_a;
    logic pt_b, hs_b, vs_b, von_b, ft_b;
    logic pt_c, hs_c, vs_c, von_c, ft_c;
    logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;

    vga_timing_gen dut_a (
        .clk(clk), .rst(rst_a), .pixel_tick(pt_a), .x(x_a), .y(y_a),
        .hsync(hs_a), .vsync(vs_a), .video_on(von_a), .frame_tick(ft_a)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_VISIBLE(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(2),
        .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(3), .V_BACK(2)
    ) dut_b (
        .clk(clk), .rst(rst_b), .pixel_tick(pt_b), .x(x_b), .y(y_b),
        .hsync(hs_b), .vsync(vs_b), .video_on(von_b), .frame_tick(ft_b)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) dut_c (
        .clk(clk), .rst(rst_c), .pixel_tick(pt_c), .x(x_c), .y(y_c),
        .hsync(hs_c), .vsync(vs_c), .video_on(von_c), .frame_tick(ft_c)
    );

    // Reference: clocks elapsed since the last reset edge; all outputs follow from it arithmetically.
    int t_a = 0, t_b = 0, t_c = 0;
    always @(posedge clk) begin
        t_a <= rst_a ? 0 : t_a + 1;
        t_b <= rst_b ? 0 : t_b + 1;
        t_c <= rst_c ? 0 : t_c + 1;
    end

    // Packed as {pixel_tick, x, y, hsync, vsync, video_on, frame_tick}.
    function automatic logic [24:0] ref_out(input int t, input int cd,
                                            input int hv, input int hf, input int hsw, input int hb,
                                            input int vv, input int vf, input int vsw, input int vb);
        int ht, vt, dv, p, px, py;
        logic r_pt, r_hs, r_vs, r_von, r_ft;
        ht    = hv + hf + hsw + hb;
        vt    = vv + vf + vsw + vb;
        dv    = t % cd;
        p     = t / cd;
        px    = p % ht;
        py    = (p / ht) % vt;
        r_pt  = (dv == cd - 1);
        r_hs  = !(px >= hv + hf && px < hv + hf + hsw);
        r_vs  = !(py >= vv + vf && py < vv + vf + vsw);
        r_von = (px < hv) && (py < vv);
        r_ft  = (dv == 0) && (px == 0) && (py == vv);
        return {r_pt, 10'(px), 10'(py), r_hs, r_vs, r_von, r_ft};
    endfunction

    task automatic check_vec(input string name, input int t, input logic [24:0] act, input logic [24:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d: got pt=%b x=%0d y=%0d hs=%b vs=%b von=%b ft=%b, want pt=%b x=%0d y=%0d hs=%b vs=%b von=%b ft=%b",
                     name, t, act[24], act[23:14], act[13:4], act[3], act[2], act[1], act[0],
                     exp[24], exp[23:14], exp[13:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Continuous comparison of every instance against the reference.
    always @(negedge clk) begin
        if (chk_en) begin
            check_vec("model_a", t_a, {pt_a, x_a, y_a, hs_a, vs_a, von_a, ft_a},
                      ref_out(t_a, 4, 640, 16, 96, 48, 480, 10, 2, 33));
            check_vec("model_b", t_b, {pt_b, x_b, y_b, hs_b, vs_b, von_b, ft_b},
                      ref_out(t_b, 3, 20, 4, 6, 2, 10, 2, 3, 2));
            check_vec("model_c", t_c, {pt_c, x_c, y_c, hs_c, vs_c, von_c, ft_c},
                      ref_out(t_c, 1, 4, 1, 2, 1, 3, 1, 1, 1));
        end
    end

    typedef struct {
        logic rst;
        int   n;
        int   ex;
        int   ey;
        logic hs;
        logic vs;
        logic von;
        logic pt;
        logic ft;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int n;
        logic prev;

        // Tiny raster: line 8 clks, frame 48 clks, hsync low x=5..6, vsync low y=4, frame_tick at (0,3).
        tbl[0]  = '{1'b1,  3, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b0,  4, 4, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0,  1, 5, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0,  2, 7, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0,  1, 0, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 16, 0, 3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{1'b0,  1, 1, 3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0,  7, 0, 4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0,  5, 5, 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 11, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 47, 7, 5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0,  1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b0,  5, 5, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b1,  1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rst_a  = 1'b0;
        rst_b  = 1'b0;

        for (int i = 0; i < 14; i++) begin
            rst_c = tbl[i].rst;
            repeat (tbl[i].n) @(negedge clk);
            check_vec($sformatf("tbl%0d", i), i, {pt_c, x_c, y_c, hs_c, vs_c, von_c, ft_c},
                      {tbl[i].pt, 10'(tbl[i].ex), 10'(tbl[i].ey), tbl[i].hs, tbl[i].vs,
                       tbl[i].von, tbl[i].ft});
        end
        rst_c = 1'b0;

        // Default raster: reset values and first pixel_tick after release.
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        check_vec("reset_a", 0, {pt_a, x_a, y_a, hs_a, vs_a, von_a, ft_a},
                  {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0});
        n = 0;
        while (!pt_a && n < 20) begin @(negedge clk); n++; end
        check_int("first_tick_delay", n, 3);
        n = 0;
        do begin @(negedge clk); n++; end while (!pt_a && n < 20);
        check_int("pixel_tick_period", n, 4);

        // hsync: falls at x=656, low for 96 pixels.
        n = 0;
        while (hs_a && n < 4000) begin @(negedge clk); n++; end
        check_int("hsync_fall_x", int'(x_a), 656);
        n = 0;
        while (!hs_a && n < 1000) begin @(negedge clk); n++; end
        check_int("hsync_low_clks", n, 384);
        check_int("hsync_rise_x", int'(x_a), 752);

        // video_on falls when x becomes 640 on the next line.
        n = 0;
        while (!von_a && n < 4000) begin @(negedge clk); n++; end
        while (von_a && n < 8000) begin @(negedge clk); n++; end
        check_int("video_off_x", int'(x_a), 640);

        // Line length measured between two hsync falling edges.
        n = 0;
        while (hs_a && n < 4000) begin @(negedge clk); n++; end
        n = 0;
        while (!hs_a && n < 5000) begin @(negedge clk); n++; end
        while (hs_a && n < 5000) begin @(negedge clk); n++; end
        check_int("line_clks", n, 3200);

        // Medium raster: frame_tick position and period (32 x 17 x 3 clks).
        n = 0;
        while (!ft_b && n < 3000) begin @(negedge clk); n++; end
        check_int("frame_tick_x", int'(x_b), 0);
        check_int("frame_tick_y", int'(y_b), 10);
        n = 0;
        do begin @(negedge clk); n++; end while (!ft_b && n < 3000);
        check_int("frame_period", n, 1632);

        // Mid-frame reset inside both sync pulses.
        n = 0;
        while (!(x_b == 10'd26 && y_b == 10'd13) && n < 3000) begin @(negedge clk); n++; end
        check_int("pre_reset_syncs", int'({hs_b, vs_b}), 0);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        check_vec("midframe_reset", 0, {pt_b, x_b, y_b, hs_b, vs_b, von_b, ft_b},
                  {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0});

        // Random reset pulses; the continuous reference comparison covers the rest.
        prev = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            rst_a = ($urandom_range(0, 299) == 0);
            rst_b = ($urandom_range(0, 99) == 0);
            rst_c = ($urandom_range(0, 39) == 0) || (prev && $urandom_range(0, 1) == 0);
            prev  = rst_c;
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        repeat (200) @(negedge clk);
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
